serial_adder_seq: RTL

- Bit-serial addition controller. It sequences one 1-bit add cell (two half-adder stages plus an OR for carry) over WIDTH clock cycles to add two WIDTH-bit operands, LSB first.
- It captures the operands, holds the running carry, counts the bits and reports the result through a start/busy/done handshake.
- It sits between a requesting block and the gate-level adder cell, so a wide add costs one cell instead of WIDTH cells.

---
 rtl/serial_adder_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/serial_adder_seq.sv
// -----------------------------------------------------------------------------
// serial_adder_seq
//
// Bit-serial addition controller. One full-add cell is reused over WIDTH
// clock cycles, LSB first. The cell is two half adders plus an OR for the
// carry. The controller captures the operands, keeps the running carry and
// counts the bits. It reports the result through a start/busy/done handshake.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset (clears all state)
//   start  in   1      request; sampled only while idle
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   busy   out  1      addition in progress
//   done   out  1      one-cycle pulse, sum/cout freshly updated
//   sum    out  WIDTH  last completed sum
//   cout   out  1      carry out of the MSB of the last completed sum
//
// Timing: start accepted at edge k -> busy for cycles k+1..k+WIDTH, done in
// the cycle after edge k+WIDTH, back in idle one edge later.
// -----------------------------------------------------------------------------
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 6 bits covers the largest legal WIDTH (32) without depending on $clog2,
  // which would collapse to zero bits at WIDTH=1.
  localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] psum_q;
  logic             carry_q;
  logic [5:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [1:0]       fa_d;
  logic             carry_d;
  logic [WIDTH:0]   psum_ext;
  logic [WIDTH-1:0] psum_d;
  logic             last_bit;

  // Gate-level cell: half adder on the operand bits, half adder adding the
  // incoming carry, OR of the two half-adder carries. Returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y,
                                          input logic ci);
    logic s1, c1, s2, c2;
    s1 = x ^ y;
    c1 = x & y;
    s2 = s1 ^ ci;
    c2 = s1 & ci;
    return {c1 | c2, s2};
  endfunction

  always_comb begin
    fa_d     = full_add(a_sh_q[0], b_sh_q[0], carry_q);
    carry_d  = fa_d[1];
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    // Concatenate-then-slice keeps this legal for WIDTH=1.
    psum_ext = {fa_d[0], psum_q};
    psum_d   = psum_ext[WIDTH:1];
    last_bit = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          // start is deliberately not looked at here: no queueing.
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          psum_q  <= psum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 6'd1;
          if (last_bit) begin
            // Only point where the visible result changes.
            sum_q   <= psum_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          // start is ignored here; the requester must present it in idle.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
